// File: rtl/fir_mac_sum_tree_pkg.sv
// Shared constants and helpers for the FIR MAC sum tree: width derivation,
// per-level node counts and signed saturation limits.
package fir_sum_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_w(input int in_w, input int num_mac);
    return in_w + clog2(num_mac);
  endfunction

  // Number of live nodes at tree level l (level 0 = the raw MAC inputs).
  function automatic int lvl_cnt(input int num_mac, input int l);
    return (num_mac + (1 << l) - 1) >> l;
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_mac_sum_tree_if.sv
// MAC-bank input and FIR-result output bundle for fir_mac_sum_tree.
interface fir_mac_sum_tree_if #(
  parameter int NUM_MAC   = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                              iEnSample600k;
  logic                              iMacValid;
  logic [NUM_MAC*IN_WIDTH-1:0]       iMacData;
  logic                              oMacReady;
  logic                              oFirValid;
  logic                              iFirReady;
  logic signed [OUT_WIDTH-1:0]       oFirOut;
  logic                              oOvfSticky;
  logic                              oOverrun;
  logic                              iFlagClr;

  modport slave (
    input  iEnSample600k, iMacValid, iMacData, iFirReady, iFlagClr,
    output oMacReady, oFirValid, oFirOut, oOvfSticky, oOverrun
  );

  modport master (
    output iEnSample600k, iMacValid, iMacData, iFirReady, iFlagClr,
    input  oMacReady, oFirValid, oFirOut, oOvfSticky, oOverrun
  );
endinterface

// File: rtl/fir_sum_round_sat.sv
// Combinational round-half-up, arithmetic right shift and narrowing of the tree sum.
// FIR_SUM_SAT_EN selects saturation (with ovf flag); otherwise the result wraps.
module fir_sum_round_sat
  import fir_sum_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic signed [ACC_W-1:0]     sum,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        ovf
);
  localparam int     RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam longint RND_L  = (SHIFT > 0) ? (64'sd1 <<< RND_SH) : 64'sd0;

  // One guard bit so the rounding increment can never wrap the sum.
  logic signed [ACC_W:0] ext_c;
  logic signed [ACC_W:0] shf_c;

  always_comb begin
    ext_c = (ACC_W+1)'(sum) + (ACC_W+1)'(RND_L);
    shf_c = ext_c >>> SHIFT;
  end

`ifdef FIR_SUM_SAT_EN
  always_comb begin
    res = OUT_WIDTH'(shf_c);
    ovf = 1'b0;
    if (longint'(shf_c) > sat_max(OUT_WIDTH)) begin
      res = OUT_WIDTH'(sat_max(OUT_WIDTH));
      ovf = 1'b1;
    end else if (longint'(shf_c) < sat_min(OUT_WIDTH)) begin
      res = OUT_WIDTH'(sat_min(OUT_WIDTH));
      ovf = 1'b1;
    end
  end
`else
  assign res = OUT_WIDTH'(shf_c);
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_sum_tree.sv
// Registered pairwise adder tree over NUM_MAC signed MAC partials, then round/shift
// and narrowing (saturating when FIR_SUM_SAT_EN is defined) with valid/ready output.
module fir_mac_sum_tree
  import fir_sum_pkg::*;
#(
  parameter int NUM_MAC   = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input logic               iClk12M,
  input logic               iRst,
  fir_mac_sum_tree_if.slave bus
);
  localparam int STAGES = clog2(NUM_MAC);
  localparam int ACC_W  = acc_w(IN_WIDTH, NUM_MAC);

  logic                        adv;
  logic                        accept;
  logic                        fir_vld_p;
  logic signed [OUT_WIDTH-1:0] fir_out_p;
  logic                        ovf_sticky;
  logic                        overrun;

  // The whole pipeline moves in lockstep: it stalls only when the output is held.
  assign adv    = !fir_vld_p | bus.iFirReady;
  assign accept = bus.iMacValid & bus.iEnSample600k & adv;

  logic signed [ACC_W-1:0] in_s [NUM_MAC];

  always_comb begin
    for (int k = 0; k < NUM_MAC; k++)
      in_s[k] = ACC_W'($signed(bus.iMacData[k*IN_WIDTH +: IN_WIDTH]));
  end

  logic signed [ACC_W-1:0] sum_c;
  logic                    vld_c;

  if (STAGES == 0) begin : g_pass
    assign sum_c = in_s[0];
    assign vld_c = accept;
  end else begin : g_tree
    logic signed [ACC_W-1:0] lvl_c [STAGES+1][NUM_MAC];
    logic signed [ACC_W-1:0] nxt_c [STAGES][NUM_MAC];
    logic signed [ACC_W-1:0] sum_p [STAGES][NUM_MAC];
    logic [STAGES-1:0]       vld_p;

    always_comb begin
      for (int j = 0; j < NUM_MAC; j++) lvl_c[0][j] = in_s[j];
      for (int l = 0; l < STAGES; l++)
        for (int j = 0; j < NUM_MAC; j++) lvl_c[l+1][j] = sum_p[l][j];
      for (int l = 0; l < STAGES; l++) begin
        for (int j = 0; j < NUM_MAC; j++) begin
          nxt_c[l][j] = '0;
          if (j < lvl_cnt(NUM_MAC, l + 1)) begin
            // An odd leftover node rides through this level unchanged.
            if (2*j + 1 < lvl_cnt(NUM_MAC, l))
              nxt_c[l][j] = lvl_c[l][2*j] + lvl_c[l][2*j+1];
            else
              nxt_c[l][j] = lvl_c[l][2*j];
          end
        end
      end
    end

    // ---- tree level registers: sum_p[l] holds level l+1 ----
    always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
        vld_p <= '0;
        sum_p <= '{default: '0};
      end else if (adv) begin
        vld_p[0] <= accept;
        for (int l = 1; l < STAGES; l++) vld_p[l] <= vld_p[l-1];
        sum_p <= nxt_c;
      end
    end

    assign sum_c = lvl_c[STAGES][0];
    assign vld_c = vld_p[STAGES-1];
  end

  logic signed [OUT_WIDTH-1:0] rs_c;
  logic                        ovf_c;

  fir_sum_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round_sat (
    .sum (sum_c),
    .res (rs_c),
    .ovf (ovf_c)
  );

  // ---- output register and sticky flags ----
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      fir_vld_p  <= 1'b0;
      fir_out_p  <= '0;
      ovf_sticky <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (adv) begin
        fir_vld_p <= vld_c;
        if (vld_c) fir_out_p <= rs_c;
      end
      if (adv & vld_c & ovf_c)    ovf_sticky <= 1'b1;
      else if (bus.iFlagClr)      ovf_sticky <= 1'b0;
      if (bus.iMacValid & bus.iEnSample600k & !adv) overrun <= 1'b1;
      else if (bus.iFlagClr)                        overrun <= 1'b0;
    end
  end

  assign bus.oMacReady  = adv;
  assign bus.oFirValid  = fir_vld_p;
  assign bus.oFirOut    = fir_out_p;
  assign bus.oOvfSticky = ovf_sticky;
  assign bus.oOverrun   = overrun;

endmodule

// File: doc/fir_mac_sum_tree.md
Name: fir_mac_sum_tree

Overview:
Parametrised successor to the fixed 4-input FIR sum stage. Reduces NUM_MAC signed MAC partial outputs through a registered pairwise adder tree, then applies an optional round/shift and saturation, and presents the FIR result with a valid/ready handshake. Sits between the MAC bank and the FIR output/DAC interface. Tracks overflow and sample overrun as sticky flags.

Parameters:
NUM_MAC, 4, number of MAC inputs (1..16; non-power-of-two allowed)
IN_WIDTH, 16, signed width of each MAC output
OUT_WIDTH, 16, signed width of oFirOut
SHIFT, 0, arithmetic right shift applied after summation (0..8), with rounding

Ports:
iClk12M  in  1  system clock, single clock domain
iRst  in  1  asynchronous, active-high reset
iEnSample600k  in  1  sample strobe; an input is accepted only in a cycle where this is high
iMacValid  in  1  iMacData holds valid partials
iMacData  in  NUM_MAC*IN_WIDTH  flattened signed partials; MAC k occupies bits [k*IN_WIDTH +: IN_WIDTH]
oMacReady  out  1  pipeline can advance this cycle
oFirValid  out  1  oFirOut valid
iFirReady  in  1  downstream accepts oFirOut
oFirOut  out  OUT_WIDTH  signed FIR result
oOvfSticky  out  1  saturation has occurred since last clear
oOverrun  out  1  sample strobe with valid data arrived while stalled
iFlagClr  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, iRst=1): all pipeline data and valid bits, oFirOut, oFirValid, oOvfSticky and oOverrun go to 0. Data and valid in flight are discarded.
- Internal sum width: ACC_W = IN_WIDTH + clog2(NUM_MAC). Every addition sign-extends to ACC_W, so the tree itself never overflows.
- Tree: STAGES = clog2(NUM_MAC) registered levels. Each level adds adjacent pairs. An odd leftover element is passed through registered unchanged.
- NUM_MAC=1 gives STAGES=0.
- Output stage (1 register):
  - If SHIFT>0: sum + (1<<(SHIFT-1)), then arithmetic shift right by SHIFT (round half toward +inf).
  - The result is then saturated to the OUT_WIDTH range. Saturation sets oOvfSticky.
- Latency: an accepted input appears on oFirOut/oFirValid exactly STAGES+1 cycles later when there is no stall. For defaults this is 3.
- Handshake:
  - adv = !oFirValid | iFirReady.
  - oMacReady = adv.
  - All stages, including the valid shift chain, advance only when adv=1. With adv=0 all registers hold.
  - Accept = iMacValid & iEnSample600k & adv. A bubble enters when accept=0 and adv=1.
  - oFirOut is stable while oFirValid=1 and iFirReady=0.
- Overrun: iMacValid & iEnSample600k & !adv sets oOverrun. That sample is dropped.
- Flag priority: in the same cycle, a set wins over iFlagClr.
- No throughput limit: one result per cycle is possible.

Optional Feature:
FIR_SUM_SAT_EN
- Defined: saturation and oOvfSticky operate as described above.
- Undefined: the output takes the low OUT_WIDTH bits of the shifted sum (two's-complement wrap), and oOvfSticky is tied to 0.
- Latency is identical in both cases.

Decomposition:
- Package fir_sum_pkg:
  - clog2 constant function
  - ACC_W derivation function
  - signed saturation helper (max/min for a given width)
- One sub-module, fir_sum_round_sat: combinational round, shift and saturate, parametrised by ACC_W, OUT_WIDTH and SHIFT. It is instantiated before the output register.
- The tree is generated inline.

Test Plan:
- Reset: hold iRst=1 with random inputs -> oFirOut=0, oFirValid=0, oMacReady=1, flags=0; deassert -> no spurious valid.
- Basic sum (defaults): inputs {100,200,-50,25} with strobe and iFirReady=1 -> oFirOut=275, valid exactly 3 cycles later; back-to-back samples -> one result per cycle, in order.
- Saturation (FIR_SUM_SAT_EN): four 0x7FFF -> 0x7FFF and oOvfSticky=1; four 0x8000 -> 0x8000; pulse iFlagClr -> flag 0. Without macro: four 0x7FFF -> 0xFFFC.
- Backpressure: stream 6 samples, iFirReady=0 for 5 cycles -> oMacReady low, oFirOut held, all 6 results delivered in order; strobe while stalled -> oOverrun=1 and that sample is absent.
- Rounding (SHIFT=2): sum 6 -> 2, sum -6 -> -1, sum 5 -> 1; NUM_MAC=3 inputs {1,2,3} -> 6 with latency 3; NUM_MAC=1 input 7 -> 7 with latency 1.
- Reset mid-operation: assert iRst with 2 samples in flight -> oFirValid=0 immediately, no stale result after release.
